// File: rtl/resource_arbiter_pkg.sv
// resource_arbiter shared definitions.
// Default sizes, FSM state codes and operand slicing helper.
package resource_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int RES_LAT_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t RESP = 2'd2;

  // Low bit of requester idx's operand in the packed req_data bus.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/resource_arbiter_if.sv
// Requester/resource side bundle of resource_arbiter.
// master = pipelines + shared resource, slave = arbiter.
interface resource_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      flush;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         res_in;
  logic                      res_valid;
  logic [DATA_W-1:0]         res_out;
  logic [DATA_W-1:0]         resp_data;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      busy;

  modport master (
    output req, req_data, flush, res_out,
    input  grant, res_in, res_valid,
    input  resp_data, resp_valid, busy
  );

  modport slave (
    input  req, req_data, flush, res_out,
    output grant, res_in, res_valid,
    output resp_data, resp_valid, busy
  );

endinterface

// File: rtl/resource_arbiter_rr_pick.sv
// Round-robin pick: first set req bit scanning from ptr upward.
// Purely combinational, wraps from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin arbiter and sequencer for a shared fixed-latency
// resource; routes each result back to its requester only.
module resource_arbiter
  import resource_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_LAT = RES_LAT_DEF
) (
  input logic               clk,
  input logic               reset,
  resource_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RES_LAT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     nxt;
  logic [CW-1:0]     cnt;
  logic              found;
  logic [DATA_W-1:0] slices [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slices[g] = bus.req_data[slice_lo(g, DATA_W) +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  assign nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // Arbitrate in IDLE, count out the resource latency, deliver result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      win            <= '0;
      cnt            <= '0;
      bus.grant      <= '0;
      bus.res_in     <= '0;
      bus.res_valid  <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_valid <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.res_valid  <= 1'b0;
      bus.resp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (found && !bus.flush) begin
            win           <= pick;
            bus.res_in    <= slices[pick];
            bus.grant     <= ONE << pick;
            bus.res_valid <= 1'b1;
            bus.busy      <= 1'b1;
            cnt           <= CW'(RES_LAT);
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            ptr       <= nxt;
            state     <= IDLE;
          end else if (cnt == '0) begin
            bus.resp_data  <= bus.res_out;
            bus.resp_valid <= ONE << win;
            bus.grant      <= '0;
            ptr            <= nxt;
            state          <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resource_arbiter.sv
// Self-checking bench for resource_arbiter: timeline model plus
// directed scenarios with hand-computed expectations.
module tb_resource_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  resource_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  resource_arbiter #(.NUM_REQ(N), .DATA_W(W), .RES_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Shared resource: echoes operand + 1, valid only LAT cycles later.
  logic         p1v = 1'b0;
  logic         p2v = 1'b0;
  logic [W-1:0] p1d;
  logic [W-1:0] p2d;

  always @(posedge clk) begin
    p1v <= bus.res_valid;
    p1d <= bus.res_in + 32'd1;
    p2v <= p1v;
    p2d <= p1d;
  end

  assign bus.res_out = p2v ? p2d : 32'hBAD0_0000;

  // Model: a transaction is a timeline anchored at its grant cycle t0.
  bit           m_active = 1'b0;
  int           m_t0  = 0;
  int           m_win = 0;
  int           m_ptr = 0;
  int           m_w;
  int           m_age;
  int           cyc   = 0;
  logic [W-1:0] m_op  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_ptr    = 0;
    end else begin
      m_age = cyc - m_t0;
      if (!m_active) begin
        if (!bus.flush && bus.req != '0) begin
          m_w = -1;
          for (int k = 0; k < N; k++)
            if (m_w < 0 && bus.req[2'((m_ptr + k) % N)])
              m_w = (m_ptr + k) % N;
          m_win    = m_w;
          m_op     = W'(bus.req_data >> (m_w * W));
          m_active = 1'b1;
          m_t0     = cyc + 1;
        end
      end else if (m_age <= LAT) begin
        if (bus.flush || m_age == LAT) m_ptr = (m_win + 1) % N;
        if (bus.flush) m_active = 1'b0;
      end else begin
        m_active = 1'b0;
      end
      cyc++;
    end
  end

  int         age;
  logic [3:0] e_g;
  logic [3:0] e_rs;
  bit         e_rv;

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    age  = cyc - m_t0;
    e_g  = (m_active && age >= 0 && age <= LAT) ? 4'(1 << m_win) : 4'b0;
    e_rv = m_active && age == 0;
    e_rs = (m_active && age == LAT + 1) ? 4'(1 << m_win) : 4'b0;
    chk("m_grant", 32'(bus.grant), 32'(e_g));
    chk("m_res_valid", 32'(bus.res_valid), 32'(e_rv));
    chk("m_resp_valid", 32'(bus.resp_valid), 32'(e_rs));
    chk("m_busy", 32'(bus.busy), 32'(m_active));
    if (e_rv) chk("m_res_in", bus.res_in, m_op);
    if (e_rs != 4'b0) chk("m_resp_data", bus.resp_data, m_op + 32'd1);
  end

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int npulse;

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.flush    = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_res_in", bus.res_in, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    reset = 1'b0;

    // Round robin with all requesters, wrapping back to 0.
    bus.req_data = {32'hA000_0003, 32'hA000_0002,
                    32'hA000_0001, 32'hA000_0000};
    bus.req = 4'b1111;
    @(negedge clk);
    chk("rr0", 32'(bus.grant), 32'(rr_exp[0]));
    for (int k = 1; k < 5; k++) begin
      repeat (4) @(negedge clk);
      chk("rr_gap", 32'(bus.grant), 0);
      @(negedge clk);
      chk("rr_order", 32'(bus.grant), 32'(rr_exp[k]));
    end
    bus.req = '0;
    repeat (5) @(negedge clk);

    // Single request to requester 2.
    bus.req_data = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
    bus.req = 4'b0100;
    @(negedge clk);
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_res_valid", 32'(bus.res_valid), 1);
    chk("single_res_in", bus.res_in, 32'hDEAD_BEEF);
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("single_hold", 32'(bus.grant), 32'h4);
    chk("single_no_resp", 32'(bus.resp_valid), 0);
    @(negedge clk);
    chk("single_resp_valid", 32'(bus.resp_valid), 32'h4);
    chk("single_resp_data", bus.resp_data, 32'hDEAD_BEF0);
    chk("single_grant_drop", 32'(bus.grant), 0);

    // Fairness: ptr is 3, so 0 beats 2.
    bus.req_data = {32'h0, 32'h2222_2222, 32'h0, 32'h1111_1111};
    bus.req = 4'b0101;
    @(negedge clk);
    chk("fair_idle", 32'(bus.grant), 0);
    @(negedge clk);
    chk("fair_grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Flush in BUSY of a grant to requester 1.
    bus.req_data = {32'h0, 32'h3333_3333, 32'h4444_4444, 32'h0};
    bus.req = 4'b0010;
    @(negedge clk);
    chk("flush_grant", 32'(bus.grant), 32'h2);
    bus.req = '0;
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_drop", 32'(bus.grant), 0);
    chk("flush_busy", 32'(bus.busy), 0);
    bus.req = 4'b0110;
    @(negedge clk);
    chk("flush_next", 32'(bus.grant), 32'h4);
    chk("flush_no_resp", 32'(bus.resp_valid), 0);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Flush in RESP and request withdrawn during BUSY.
    bus.req_data = {32'h1234_5678, 32'h0, 32'h0, 32'h0};
    bus.req = 4'b1000;
    @(negedge clk);
    chk("resp_flush_grant", 32'(bus.grant), 32'h8);
    bus.req = '0;
    npulse = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) begin
        npulse++;
        chk("resp_flush_valid", 32'(bus.resp_valid), 32'h8);
        chk("resp_flush_data", bus.resp_data, 32'h1234_5679);
      end
      bus.flush = (i == 3);
    end
    chk("resp_once", npulse, 1);

    // Asynchronous reset in the middle of a transaction.
    bus.req_data = {32'h7777_7777, 32'h5555_5555, 32'h0, 32'h0};
    bus.req = 4'b0100;
    @(negedge clk);
    chk("areset_pre", 32'(bus.res_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_grant", 32'(bus.grant), 0);
    chk("areset_res_valid", 32'(bus.res_valid), 0);
    chk("areset_resp_valid", 32'(bus.resp_valid), 0);
    chk("areset_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b1000;
    @(negedge clk);
    chk("areset_regrant", 32'(bus.grant), 32'h8);
    chk("areset_res_in", bus.res_in, 32'h7777_7777);
    bus.req = '0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/resource_arbiter.md
Name: resource_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared resource used by several pipeline_top instances.
- Consumes each pipeline's arbiter_req and resource_input, and returns arbiter_grant.
- Forwards the winner's operand to the shared resource, waits a fixed resource latency, and routes the result back to that requester only.
- Sits directly downstream of the pipelines' arbiter interface, between them and the shared resource.

Parameters:
- NUM_REQ, 4: number of requesting pipelines, at least 2.
- DATA_W, 32: operand and result width.
- RES_LAT, 2: resource latency in cycles from res_valid to a valid res_out, at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request (arbiter_req of each pipeline).
- req_data  in  NUM_REQ*DATA_W  per-requester operand, slice i = bits [i*DATA_W +: DATA_W].
- flush  in  1  abort the in-flight transaction.
- grant  out  NUM_REQ  one-hot grant (arbiter_grant of each pipeline).
- res_in  out  DATA_W  operand to the shared resource.
- res_valid  out  1  one-cycle issue strobe to the resource.
- res_out  in  DATA_W  resource result, valid RES_LAT cycles after res_valid.
- resp_data  out  DATA_W  result broadcast to all requesters.
- resp_valid  out  NUM_REQ  one-hot result strobe.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state = IDLE, ptr = 0, cnt = 0;
  - grant, res_in, res_valid, resp_data, resp_valid and busy all = 0.
- All outputs are registered.

States:
- IDLE:
  - Each cycle, pick the first asserted req[i] scanning ptr, ptr+1, … NUM_REQ-1, 0, … (wraps).
  - If a winner exists and flush = 0:
    - latch win = i and res_in = req_data slice i;
    - next cycle (T): grant[i] = 1, res_valid = 1, cnt = RES_LAT, state = BUSY.
  - With flush = 1, or no req asserted, stay in IDLE.
- BUSY:
  - Cycles T .. T+RES_LAT.
  - grant[win] is held high throughout.
  - res_valid is high only in cycle T.
  - cnt decrements each cycle.
  - In the cycle where cnt == 0 (cycle T+RES_LAT), sample res_out and go to RESP.
- RESP:
  - Cycle T+RES_LAT+1: resp_valid[win] = 1, resp_data = the captured result, grant = 0.
  - ptr = win+1, wrapping NUM_REQ-1 → 0.
  - Next state is IDLE.
  - The earliest next grant is at T+RES_LAT+3.

Timing:
- Total latency from the cycle req is sampled to resp_valid is RES_LAT+2 cycles.

Handshake and boundary rules:
- A requester must hold req and req_data stable until it sees grant. req_data is sampled only at the arbitration edge.
- req changes during BUSY or RESP are ignored. Deasserting req while granted does not abort the transaction.
- flush while BUSY:
  - next cycle grant = 0 and state = IDLE;
  - no resp_valid is issued, and the late res_out is discarded;
  - ptr still advances to win+1 (fairness is preserved).
- flush in RESP has no effect: the response is still delivered.
- flush in IDLE suppresses arbitration for that cycle only.
- With all req asserted, grants rotate 0, 1, 2, 3, 0, … No requester waits more than NUM_REQ-1 transactions.
- Reset mid-transaction drops grant and res_valid immediately (asynchronous). No response is issued.
- resp_valid is never asserted for more than one bit or for more than one cycle per transaction.
- Width of cnt is $clog2(RES_LAT+1). Width of ptr and win is $clog2(NUM_REQ).

Decomposition:
- Package resource_arbiter_pkg holds:
  - the state enum {IDLE, BUSY, RESP};
  - the default parameters;
  - the function for slicing req_data.
- One combinational sub-module, rr_pick, takes req and ptr and produces a found flag and the winner index. It contains the rotate-and-priority-encode logic and is reusable by other arbiters.
- The FSM, counter and data registers stay in resource_arbiter.

Test Plan:
All scenarios use NUM_REQ=4 and RES_LAT=2.
1. Single request:
   - Stimulus: reset, then req = 0100 with slice 2 = 0xDEAD_BEEF in cycle 0; resource echoes its input plus 1.
   - Required: grant = 0100 and res_valid at cycle 1 with res_in = 0xDEAD_BEEF; resp_valid = 0100 and resp_data = 0xDEAD_BEF0 at cycle 4; grant = 0 at cycle 4; ptr = 3.
2. Round-robin with wrap:
   - Stimulus: req = 1111 held for 5 transactions.
   - Required: grant order 0001, 0010, 0100, 1000, 0001; transactions 5 cycles apart.
3. Fairness from ptr:
   - Stimulus: after serving requester 2, req = 0101.
   - Required: requester 0 is granted (scan 3 → 0), not requester 2.
4. Flush in BUSY:
   - Stimulus: flush = 1 in cycle T+1 of a grant to requester 1.
   - Required: grant = 0 at T+2; no resp_valid; ptr = 2; a new arbitration is possible at T+2.
5. Asynchronous reset mid-BUSY:
   - Stimulus: assert reset between clock edges during a transaction.
   - Required: grant, res_valid, resp_valid and busy go to 0 immediately; after release with req = 1000, requester 3 is granted and ptr restarts from 0.
6. Flush in RESP and request drop:
   - Stimulus: flush during RESP, and req withdrawn during BUSY.
   - Required: resp_valid is still issued exactly once with the correct data.
